// File: rtl/stack_pkg.sv
// Shared operation encoding for the return stack controller and its storage.
package stack_pkg;

  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } op_e;

  // True for the ops that write din into storage.
  function automatic logic op_writes(op_e op);
    return (op == OP_PUSH) || (op == OP_REPLACE);
  endfunction

endpackage

// File: rtl/stack_regfile.sv
// Return stack storage: DEPTH x WIDTH, single write port, async read of the top entry.
module stack_regfile
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  op_e              op,
  input  logic [AW-1:0]    push_addr,
  input  logic [AW-1:0]    top_addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    waddr;

  // A push lands one above the top; a replace overwrites the top itself.
  assign waddr = (op == OP_PUSH) ? push_addr : top_addr;

  always_ff @(posedge clk) begin
    if (op_writes(op)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[top_addr];

endmodule

// File: rtl/return_stack.sv
// Hardware return-address stack with sticky overflow/underflow flags.
module return_stack
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic                       clr_err,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  op_e           op;
  logic [CW-1:0] count_nxt;
  logic          ovf_det;
  logic          unf_det;
  logic [AW-1:0] push_addr;
  logic [AW-1:0] top_addr;
  logic [WIDTH-1:0] rdata;

  // Request decode; flush dominates and never raises an error.
  always_comb begin
    op        = OP_NONE;
    count_nxt = count;
    ovf_det   = 1'b0;
    unf_det   = 1'b0;
    if (flush) begin
      count_nxt = '0;
    end else if (push && pop) begin
      if (count != '0) op = OP_REPLACE;
      else             unf_det = 1'b1;
    end else if (push) begin
      if (count < DEPTH_C) begin
        op        = OP_PUSH;
        count_nxt = count + CW'(1);
      end else begin
        ovf_det = 1'b1;
      end
    end else if (pop) begin
      if (count != '0) begin
        op        = OP_POP;
        count_nxt = count - CW'(1);
      end else begin
        unf_det = 1'b1;
      end
    end
  end

  // Pointer and sticky flags; a same-cycle error beats clr_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_nxt;
      overflow  <= ovf_det | (overflow & ~clr_err);
      underflow <= unf_det | (underflow & ~clr_err);
    end
  end

  assign push_addr = AW'(count);
  assign top_addr  = AW'(count - CW'(1));

  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk       (clk),
    .op        (op),
    .push_addr (push_addr),
    .top_addr  (top_addr),
    .wdata     (din),
    .rdata     (rdata)
  );

  assign dout  = (count != '0) ? rdata : '0;
  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

endmodule

// File: tb/tb_return_stack.sv
// Randomized bench for return_stack against a queue-based model, plus directed literal checks.
module tb_return_stack;

  localparam int unsigned WIDTH = 12;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             push = 1'b0, pop = 1'b0, flush = 1'b0, clr_err = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic [CW-1:0]    count;
  logic             empty, full, overflow, underflow;

  return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .clr_err(clr_err),
    .din(din), .dout(dout), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  bit          cmp_en  = 1'b0;

  logic [WIDTH-1:0] model_q [$];
  bit               m_ovf = 1'b0;
  bit               m_unf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [WIDTH-1:0] m_top();
    return (model_q.size() > 0) ? model_q[model_q.size()-1] : '0;
  endfunction

  // Reference behaviour of one clock edge, stated as stack operations.
  task automatic model_step(input bit p, input bit q, input bit f, input bit c, input logic [WIDTH-1:0] d);
    bit eo = 0, eu = 0;
    if (f) model_q.delete();
    else if (p && q) begin
      if (model_q.size() > 0) model_q[model_q.size()-1] = d; else eu = 1;
    end else if (p) begin
      if (model_q.size() < DEPTH) model_q.push_back(d); else eo = 1;
    end else if (q) begin
      if (model_q.size() > 0) void'(model_q.pop_back()); else eu = 1;
    end
    m_ovf = eo || (m_ovf && !c);
    m_unf = eu || (m_unf && !c);
  endtask

  task automatic step(input bit p, input bit q, input bit f, input bit c, input logic [WIDTH-1:0] d);
    push = p; pop = q; flush = f; clr_err = c; din = d;
    @(posedge clk);
    if (!rst) model_step(p, q, f, c, d);
    #1;
    push = 0; pop = 0; flush = 0; clr_err = 0;
  endtask

  // Compare process: every falling edge once the model is in sync.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("dout",      32'(dout),      32'(m_top()));
      check("count",     32'(count),     32'(model_q.size()));
      check("empty",     32'(empty),     32'(model_q.size() == 0));
      check("full",      32'(full),      32'(model_q.size() == DEPTH));
      check("overflow",  32'(overflow),  32'(m_ovf));
      check("underflow", 32'(underflow), 32'(m_unf));
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_q.delete(); m_ovf = 0; m_unf = 0;
    cmp_en = 1'b1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_dout",  32'(dout),  32'd0);
    check("rst_flags", 32'({overflow, underflow}), 32'd0);

    // Basic push/pop
    step(1,0,0,0,12'h00A); step(1,0,0,0,12'h00B); step(1,0,0,0,12'h00C);
    check("p3_count", 32'(count), 32'd3);
    check("p3_dout",  32'(dout),  32'h00C);
    step(0,1,0,0,'0);
    check("pop_dout",  32'(dout),  32'h00B);
    check("pop_count", 32'(count), 32'd2);

    // Fill then overflow
    step(0,0,1,0,'0);
    for (int i = 1; i <= DEPTH; i++) step(1,0,0,0,WIDTH'(i * 'h11));
    step(1,0,0,0,12'hFFF);
    check("ovf_full",  32'(full),     32'd1);
    check("ovf_flag",  32'(overflow), 32'd1);
    check("ovf_count", 32'(count),    32'(DEPTH));
    check("ovf_dout",  32'(dout),     32'h088);

    // Replace while full
    step(0,0,0,1,'0);
    step(1,1,0,0,12'h456);
    check("rep_full_full", 32'(full),     32'd1);
    check("rep_full_ovf",  32'(overflow), 32'd0);
    check("rep_full_dout", 32'(dout),     32'h456);

    // Replace with count=2
    step(0,0,1,0,'0);
    step(1,0,0,0,12'h111); step(1,0,0,0,12'h123);
    step(1,1,0,0,12'h456);
    check("rep_count", 32'(count), 32'd2);
    check("rep_dout",  32'(dout),  32'h456);
    check("rep_flags", 32'({overflow, underflow}), 32'd0);

    // Underflow and clear
    step(0,0,1,0,'0);
    step(0,1,0,0,'0);
    check("unf_flag",  32'(underflow), 32'd1);
    check("unf_count", 32'(count),     32'd0);
    check("unf_dout",  32'(dout),      32'd0);
    step(0,0,0,1,'0);
    check("unf_clr", 32'(underflow), 32'd0);

    // Flush beats push, flags untouched
    step(0,1,0,0,'0);
    for (int i = 0; i < 5; i++) step(1,0,0,0,WIDTH'(i + 1));
    step(1,0,1,0,12'h777);
    check("fl_count", 32'(count),     32'd0);
    check("fl_empty", 32'(empty),     32'd1);
    check("fl_unf",   32'(underflow), 32'd1);
    check("fl_ovf",   32'(overflow),  32'd0);

    // Push/pop onto empty: underflow, no write
    step(0,0,0,1,'0);
    step(1,1,0,0,12'h3A3);
    check("pp_empty_unf",   32'(underflow), 32'd1);
    check("pp_empty_count", 32'(count),     32'd0);

    // Randomized traffic
    for (int i = 0; i < 800; i++)
      step($urandom_range(0,99) < 50, $urandom_range(0,99) < 45,
           $urandom_range(0,99) < 3,  $urandom_range(0,99) < 6, WIDTH'($urandom));

    // Asynchronous reset in the middle of a push
    step(1,0,0,0,12'h5A5); step(1,0,0,0,12'h6B6);
    push = 1; din = 12'h7C7;
    #2 rst = 1;
    model_q.delete(); m_ovf = 0; m_unf = 0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_full",  32'(full),  32'd0);
    check("arst_dout",  32'(dout),  32'd0);
    check("arst_flags", 32'({overflow, underflow}), 32'd0);
    @(posedge clk);
    #1 rst = 0; push = 0;
    step(0,0,0,0,'0);
    check("arst_rel_count", 32'(count), 32'd0);
    step(1,0,0,0,12'h0AB);
    check("arst_first_push_count", 32'(count), 32'd1);
    check("arst_first_push_dout",  32'(dout),  32'h0AB);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
